// File: rtl/cp0_unit.sv
// Coprocessor-0 for the pipelined MIPS core: trap decision at the memory stage,
// SR/Cause/EPC state, mfc0/mtc0 access and eret handling.
module cp0_unit #(
    parameter logic [31:0] PRID    = 32'h0000_1234,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic [5:0]  ip_r;
    logic [4:0]  exc_code_r;
    logic [31:0] epc_r;

    logic        int_req_s;
    logic        exc_req_s;
    logic        req_s;
    logic [31:0] trap_epc_s;

    // Trap decision; the rst_n gate keeps req low while registers are held in reset.
    always_comb begin
        int_req_s  = (|(hw_int & im_r)) & ie_r & ~exl_r;
        exc_req_s  = (exc_code != 5'd0) & ~exl_r;
        req_s      = rst_n & (int_req_s | exc_req_s);
        trap_epc_s = bd_in ? (vpc - 32'd4) : vpc;
    end

    // CP0 state: trap capture beats eret, which beats mtc0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_r       <= 6'd0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            bd_r       <= 1'b0;
            ip_r       <= 6'd0;
            exc_code_r <= 5'd0;
            epc_r      <= 32'd0;
        end else begin
            ip_r <= hw_int;
            if (req_s) begin
                exl_r      <= 1'b1;
                exc_code_r <= int_req_s ? 5'd0 : exc_code;
                bd_r       <= bd_in;
                epc_r      <= trap_epc_s;
            end else if (eret) begin
                exl_r <= 1'b0;
            end else if (we) begin
                case (addr)
                    REG_SR: begin
                        im_r  <= wdata[15:10];
                        exl_r <= wdata[1];
                        ie_r  <= wdata[0];
                    end
                    REG_EPC: epc_r <= wdata;
                    default: begin
                    end
                endcase
            end else begin
                exl_r <= exl_r;
            end
        end
    end

    // mfc0 read mux; not bypassed, so a same-cycle mtc0 shows up next cycle.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            REG_SR:    rdata = {16'd0, im_r, 8'd0, exl_r, ie_r};
            REG_CAUSE: rdata = {bd_r, 15'd0, ip_r, 3'd0, exc_code_r, 2'd0};
            REG_EPC:   rdata = epc_r;
            REG_PRID:  rdata = PRID;
            default:   rdata = 32'd0;
        endcase
    end

    // EPC bypass lets an eret right behind an mtc0 EPC return to the new address.
    always_comb begin
        req        = req_s;
        handler_pc = HANDLER;
        if (we && (addr == REG_EPC)) begin
            epc_out = wdata;
        end else begin
            epc_out = epc_r;
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed, table-driven bench for cp0_unit: one row per clock cycle with
// hand-computed req/rdata/epc_out, plus a mid-cycle reset sequence.
module tb_cp0_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    int n_cmp;
    int n_bad;

    cp0_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .we         (we),
        .wdata      (wdata),
        .rdata      (rdata),
        .vpc        (vpc),
        .bd_in      (bd_in),
        .exc_code   (exc_code),
        .hw_int     (hw_int),
        .eret       (eret),
        .req        (req),
        .handler_pc (handler_pc),
        .epc_out    (epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [4:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        eret;
        logic        e_req;
        logic [31:0] e_rdata;
        logic [31:0] e_epc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [4:0] a, logic w, logic [31:0] wd,
                                logic [31:0] pc, logic b, logic [4:0] ec, logic [5:0] h,
                                logic er, logic xq, logic [31:0] xr, logic [31:0] xe);
        vec_t v;
        v.rst_n = r;  v.addr = a;   v.we = w;      v.wdata = wd;
        v.vpc = pc;   v.bd = b;     v.exc = ec;    v.hw = h;
        v.eret = er;  v.e_req = xq; v.e_rdata = xr; v.e_epc = xe;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0; addr = 5'd0; we = 1'b0; wdata = 32'd0; vpc = 32'd0;
        bd_in = 1'b0; exc_code = 5'd0; hw_int = 6'd0; eret = 1'b0;

        //               rst  addr   we    wdata          vpc           bd    exc    hw         eret  req   rdata          epc_out
        tbl.push_back(mk(1'b0, 5'd12, 1'b0, 32'd0,         32'd0,        1'b0, 5'd12, 6'd0,      1'b0, 1'b0, 32'd0,         32'd0));
        tbl.push_back(mk(1'b0, 5'd13, 1'b0, 32'd0,         32'd0,        1'b0, 5'd12, 6'd0,      1'b0, 1'b0, 32'd0,         32'd0));
        tbl.push_back(mk(1'b0, 5'd14, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'd0,         32'd0));
        tbl.push_back(mk(1'b0, 5'd15, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'h0000_1234, 32'd0));
        tbl.push_back(mk(1'b0, 5'd14, 1'b1, 32'h55,        32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'd0,         32'h55));
        tbl.push_back(mk(1'b1, 5'd14, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'd0,         32'd0));
        // overflow, then a nested trap that must be ignored, then eret
        tbl.push_back(mk(1'b1, 5'd14, 1'b0, 32'd0,         32'h3010,     1'b0, 5'd12, 6'd0,      1'b0, 1'b1, 32'd0,         32'd0));
        tbl.push_back(mk(1'b1, 5'd14, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'h3010,      32'h3010));
        tbl.push_back(mk(1'b1, 5'd13, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'h30,        32'h3010));
        tbl.push_back(mk(1'b1, 5'd12, 1'b0, 32'd0,         32'h9999,     1'b1, 5'd10, 6'd0,      1'b0, 1'b0, 32'h2,         32'h3010));
        tbl.push_back(mk(1'b1, 5'd13, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'h30,        32'h3010));
        tbl.push_back(mk(1'b1, 5'd14, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b1, 1'b0, 32'h3010,      32'h3010));
        // delay-slot AdES
        tbl.push_back(mk(1'b1, 5'd12, 1'b0, 32'd0,         32'h3020,     1'b1, 5'd5,  6'd0,      1'b0, 1'b1, 32'd0,         32'h3010));
        tbl.push_back(mk(1'b1, 5'd13, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'h8000_0014, 32'h301C));
        tbl.push_back(mk(1'b1, 5'd14, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b1, 1'b0, 32'h301C,      32'h301C));
        // EPC wrap: vpc 0 in a delay slot
        tbl.push_back(mk(1'b1, 5'd12, 1'b0, 32'd0,         32'd0,        1'b1, 5'd10, 6'd0,      1'b0, 1'b1, 32'd0,         32'h301C));
        tbl.push_back(mk(1'b1, 5'd14, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        tbl.push_back(mk(1'b1, 5'd13, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'h8000_0028, 32'hFFFF_FFFC));
        // interrupt beats exception
        tbl.push_back(mk(1'b1, 5'd12, 1'b1, 32'h0000_0401, 32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'd0,         32'hFFFF_FFFC));
        tbl.push_back(mk(1'b1, 5'd12, 1'b0, 32'd0,         32'h3040,     1'b0, 5'd4,  6'b000001, 1'b0, 1'b1, 32'h401,       32'hFFFF_FFFC));
        tbl.push_back(mk(1'b1, 5'd13, 1'b0, 32'd0,         32'h3044,     1'b0, 5'd4,  6'b000001, 1'b0, 1'b0, 32'h400,       32'h3040));
        tbl.push_back(mk(1'b1, 5'd12, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'h403,       32'h3040));
        // mtc0 EPC then eret
        tbl.push_back(mk(1'b1, 5'd14, 1'b1, 32'h3100,      32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'h3040,      32'h3100));
        tbl.push_back(mk(1'b1, 5'd14, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b1, 1'b0, 32'h3100,      32'h3100));
        // masked line: no trap, IP shows it one edge late
        tbl.push_back(mk(1'b1, 5'd12, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'b000010, 1'b0, 1'b0, 32'h401,       32'h3100));
        tbl.push_back(mk(1'b1, 5'd13, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'h800,       32'h3100));
        // mtc0 discarded under a trap
        tbl.push_back(mk(1'b1, 5'd14, 1'b1, 32'hDEAD_0000, 32'h3200,     1'b0, 5'd0,  6'b000001, 1'b0, 1'b1, 32'h3100,      32'hDEAD_0000));
        tbl.push_back(mk(1'b1, 5'd14, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'h3200,      32'h3200));
        // write masking
        tbl.push_back(mk(1'b1, 5'd12, 1'b1, 32'hFFFF_FFFF, 32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'h403,       32'h3200));
        tbl.push_back(mk(1'b1, 5'd12, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_FC03, 32'h3200));
        tbl.push_back(mk(1'b1, 5'd13, 1'b1, 32'hFFFF_FFFF, 32'd0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h400,       32'h3200));
        tbl.push_back(mk(1'b1, 5'd13, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h400,       32'h3200));
        tbl.push_back(mk(1'b1, 5'd10, 1'b1, 32'h1234_5678, 32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'd0,         32'h3200));
        tbl.push_back(mk(1'b1, 5'd10, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b1, 1'b0, 32'd0,         32'h3200));
        tbl.push_back(mk(1'b1, 5'd12, 1'b0, 32'd0,         32'h3300,     1'b0, 5'd0,  6'b000001, 1'b0, 1'b1, 32'h0000_FC01, 32'h3200));
        tbl.push_back(mk(1'b1, 5'd13, 1'b0, 32'd0,         32'd0,        1'b0, 5'd0,  6'd0,      1'b0, 1'b0, 32'h400,       32'h3300));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n    = tbl[i].rst_n;
            addr     = tbl[i].addr;
            we       = tbl[i].we;
            wdata    = tbl[i].wdata;
            vpc      = tbl[i].vpc;
            bd_in    = tbl[i].bd;
            exc_code = tbl[i].exc;
            hw_int   = tbl[i].hw;
            eret     = tbl[i].eret;
            #1;
            chk("req", i, {31'd0, req}, {31'd0, tbl[i].e_req});
            chk("rdata", i, rdata, tbl[i].e_rdata);
            chk("epc_out", i, epc_out, tbl[i].e_epc);
        end
        chk("handler_pc", 0, handler_pc, 32'h0000_4180);

        // Asynchronous reset mid-cycle, then a mid-cycle release followed by a normal trap.
        @(negedge clk);
        addr = 5'd14; we = 1'b0; eret = 1'b0; hw_int = 6'd0; exc_code = 5'd12;
        vpc = 32'd0; bd_in = 1'b0;
        #1;
        chk("exl_hold_req", 0, {31'd0, req}, 32'd0);
        chk("exl_hold_epc", 0, rdata, 32'h3300);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_req", 0, {31'd0, req}, 32'd0);
        chk("async_rst_epc", 0, rdata, 32'd0);
        addr = 5'd12;
        #1;
        chk("async_rst_sr", 0, rdata, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        addr = 5'd14; vpc = 32'h4000;
        #1;
        chk("post_rst_req", 0, {31'd0, req}, 32'd1);
        @(posedge clk);
        #1;
        exc_code = 5'd0;
        #1;
        chk("post_rst_epc", 0, rdata, 32'h4000);
        chk("post_rst_epc_out", 0, epc_out, 32'h4000);
        chk("post_rst_exl_req", 0, {31'd0, req}, 32'd0);
        addr = 5'd13;
        #1;
        chk("post_rst_cause", 0, rdata, 32'h30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 exception and interrupt controller for the pipelined MIPS core. It sits at the memory stage and consumes the overflow and address-error flags that the execute-stage ALU raises, along with fetch and decode exceptions and six external interrupt lines. It decides whether the pipeline must trap, records the trap state (SR, Cause, EPC), and serves mfc0, mtc0 and eret.

## Interface
Parameters:
- PRID, 32'h0000_1234, read-only value returned for register 15.
- HANDLER, 32'h0000_4180, exception vector, exported on `handler_pc`.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- addr  in  5  CP0 register number for mfc0/mtc0.
- we  in  1  mtc0 write enable.
- wdata  in  32  mtc0 data.
- rdata  out  32  mfc0 data, combinational from `addr`.
- vpc  in  32  PC of the instruction in the memory stage.
- bd_in  in  1  memory-stage instruction is in a branch delay slot.
- exc_code  in  5  pending exception code; 0 means none (4 AdEL, 5 AdES, 10 RI, 12 Ov).
- hw_int  in  6  external interrupt lines, level-sensitive.
- eret  in  1  eret in memory stage.
- req  out  1  trap now: flush the pipeline and fetch from `handler_pc`.
- handler_pc  out  32  equals HANDLER.
- epc_out  out  32  return address for eret.

## Operation
- Register 12, SR: IM = bits 15:10, EXL = bit 1, IE = bit 0. All other bits read 0.
- Register 13, Cause: BD = bit 31, IP = bits 15:10, ExcCode = bits 6:2. Cause is read-only to mtc0.
- Register 14, EPC: 32 bits, fully writable.
- Register 15, PRId: returns PRID.
- Any other address reads 0, and writes to it are ignored.
- int_req = |(hw_int & IM) & IE & !EXL.
- exc_req = (exc_code != 0) & !EXL.
- req = int_req | exc_req. `req` is forced to 0 while rst_n is low.
- Priority: an interrupt beats a synchronous exception. On an interrupt, ExcCode is 0.
- On req at a clock edge:
  - EXL <= 1.
  - ExcCode <= (int_req ? 0 : exc_code).
  - BD <= bd_in.
  - EPC <= (bd_in ? vpc - 4 : vpc), with 32-bit wrap (vpc = 0 with bd_in gives 32'hFFFF_FFFC).
- On req, any mtc0 in the same cycle is discarded.
- On eret (without req): EXL <= 0. eret and mtc0 never coincide; that is a decoder guarantee and is not checked.
- mtc0 to SR writes only IM, EXL and IE. Bits written to other positions are dropped.
- IP <= hw_int every cycle, regardless of req or EXL.
- epc_out = (we && addr == 14) ? wdata : EPC. This bypass lets an eret directly behind an mtc0 EPC see the new value.
- mfc0 reads are not bypassed. A same-cycle mtc0 is visible on `rdata` from the next cycle.

## Timing
- Reset (asynchronous, rst_n low):
  - SR = 0, Cause = 0, EPC = 0.
  - rdata follows addr (PRId still readable); req = 0; epc_out = 0 unless the bypass applies.
- `req` is combinational in the cycle the faulting instruction occupies the memory stage. Register updates land at the following rising edge.
- Latency from trap to handler: 1 edge. Once EXL = 1, req stays 0 until eret or mtc0 clears EXL.
- Nested trap while EXL = 1: ignored completely. EPC, Cause.ExcCode and BD are unchanged.
- Interrupt raised and dropped within the same cycle: the trap is taken only if the line was high while req was evaluated.
- hw_int released before IE is set: no trap. IP reflects the line one edge late.
- Reset deasserted mid-cycle: the first edge after deassertion behaves normally.

## Test plan
- Reset: rst_n = 0 with exc_code = 12 -> req = 0; reading SR, Cause and EPC returns 0; reading addr 15 returns 32'h0000_1234.
- Overflow: vpc = 32'h0000_3010, exc_code = 12, bd_in = 0 -> req = 1 for that cycle. After the edge, EPC = 32'h0000_3010, Cause = 32'h0000_0030, SR.EXL = 1.
- Delay-slot address error: vpc = 32'h0000_3020, bd_in = 1, exc_code = 5 -> EPC = 32'h0000_301C, Cause = 32'h8000_0014.
- Interrupt vs exception: SR = 32'h0000_0401, hw_int = 6'b000001, exc_code = 4 in the same cycle -> ExcCode = 0, IP = 6'b000001. A second exc_code = 4 on the next cycle gives req = 0 (EXL held).
- mtc0/eret: mtc0 EPC = 32'h0000_3100 with eret in the next cycle. In the write cycle epc_out = 32'h0000_3100 via the bypass. eret clears EXL, and readback of SR = 32'h0000_0401.
- Write masking: mtc0 SR = 32'hFFFF_FFFF -> SR reads 32'h0000_FC03. mtc0 Cause = 32'hFFFF_FFFF -> Cause unchanged.
